// File: rtl/multi_cycle_fsm_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM:
// state encoding, datapath select encodings, ALU op codes and opcodes.
package multi_cycle_fsm_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    A_PC = 2'd0, A_OLD_PC = 2'd1, A_RD1 = 2'd2, A_ZERO = 2'd3
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    B_RD2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    RES_ALU_OUT_Q = 2'd0, RES_DATA_Q = 2'd1, RES_ALU_RESULT = 2'd2
  } result_sel_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
  } imm_sel_t;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0, CLS_SUB = 2'd1, CLS_RTYPE = 2'd2, CLS_ITYPE = 2'd3
  } alu_class_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef struct packed {
    logic        pc_write_en;
    logic        old_pc_write_en;
    logic        instruction_reg_write;
    logic        address_src;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        reg_write_en;
    alu_a_sel_t  alu_a_sel;
    alu_b_sel_t  alu_b_sel;
    logic [3:0]  alu_op;
    result_sel_t result_sel;
    imm_sel_t    imm_sel;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic imm_sel_t imm_sel_for(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_fsm_controller_alu_op_decoder.sv
// Combinational ALU operation decode from the state's ALU class and the
// instruction's funct3/funct7bit5, plus a flag for supported ALU funct3 codes.
module multi_cycle_fsm_controller_alu_op_decoder
  import multi_cycle_fsm_controller_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7bit5,
  output logic [3:0]  alu_op,
  output logic        funct3_legal
);

  logic [3:0] map_op_s;

  // funct3 map shared by register and immediate ALU instructions
  always_comb begin
    map_op_s     = ALU_ADD;
    funct3_legal = 1'b1;
    case (funct3)
      3'b000:  map_op_s = ALU_ADD;
      3'b111:  map_op_s = ALU_AND;
      3'b110:  map_op_s = ALU_OR;
      3'b010:  map_op_s = ALU_SLT;
      3'b100:  map_op_s = ALU_XOR;
      default: funct3_legal = 1'b0;
    endcase
  end

  // Final op selection; only register-form add honours funct7bit5
  always_comb begin
    alu_op = ALU_ADD;
    case (alu_class)
      CLS_SUB:   alu_op = ALU_SUB;
      CLS_RTYPE: alu_op = ((funct3 == 3'b000) && funct7bit5) ? ALU_SUB : map_op_s;
      CLS_ITYPE: alu_op = map_op_s;
      default:   alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_fsm_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives every datapath enable and select.
module multi_cycle_fsm_controller
  import multi_cycle_fsm_controller_pkg::*;
#(
  parameter bit MEM_HANDSHAKE      = 1'b1,
  parameter bit SUPPORT_BRANCH_EXT = 1'b1,
  parameter bit SUPPORT_JALR_LUI   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  input  logic       i_ltFlag,
  input  logic       i_memReady,
  output logic       o_pcWriteEn,
  output logic       o_oldPcWriteEn,
  output logic       o_instructionRegWrite,
  output logic       o_addressSrc,
  output logic       o_memReadEn,
  output logic       o_memWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_aluInputASel,
  output logic [1:0] o_aluInputBSel,
  output logic [3:0] o_aluLogicOperation,
  output logic [1:0] o_resultSel,
  output logic [2:0] o_immSel,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t     state_r;
  state_t     next_state_s;
  state_t     decode_target_s;
  alu_class_t alu_class_s;
  logic [3:0] alu_op_s;
  logic       funct3_legal_s;
  logic       ready_s;
  logic       branch_legal_s;
  logic       taken_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  assign ready_s = MEM_HANDSHAKE ? i_memReady : 1'b1;

  assign alu_class_s = (state_r == S_EXECUTER) ? CLS_RTYPE :
                       (state_r == S_EXECUTEI) ? CLS_ITYPE :
                       (state_r == S_BRANCH)   ? CLS_SUB   : CLS_ADD;

  multi_cycle_fsm_controller_alu_op_decoder u_alu_op_decoder (
    .alu_class    (alu_class_s),
    .funct3       (i_funct3),
    .funct7bit5   (i_funct7bit5),
    .alu_op       (alu_op_s),
    .funct3_legal (funct3_legal_s)
  );

  assign branch_legal_s = (i_funct3 == F3_BEQ) ||
                          (SUPPORT_BRANCH_EXT && ((i_funct3 == F3_BNE) ||
                           (i_funct3 == F3_BLT) || (i_funct3 == F3_BGE)));

  // Branch condition evaluated on the flags of the comparison in BRANCH
  always_comb begin
    taken_s = 1'b0;
    case (i_funct3)
      F3_BEQ:  taken_s = i_zeroFlag;
      F3_BNE:  taken_s = ~i_zeroFlag;
      F3_BLT:  taken_s = i_ltFlag;
      F3_BGE:  taken_s = ~i_ltFlag;
      default: taken_s = 1'b0;
    endcase
  end

  // Decode dispatch; anything unsupported lands in the sticky trap
  always_comb begin
    decode_target_s = S_TRAP;
    case (i_operand)
      OP_LOAD, OP_STORE: decode_target_s = (i_funct3 == F3_WORD) ? S_MEMADR : S_TRAP;
      OP_RTYPE:  decode_target_s = funct3_legal_s ? S_EXECUTER : S_TRAP;
      OP_ITYPE:  decode_target_s = funct3_legal_s ? S_EXECUTEI : S_TRAP;
      OP_BRANCH: decode_target_s = branch_legal_s ? S_BRANCH : S_TRAP;
      OP_JAL:    decode_target_s = S_JUMP;
      OP_JALR:   decode_target_s = (SUPPORT_JALR_LUI && (i_funct3 == 3'b000)) ? S_JALR : S_TRAP;
      OP_LUI:    decode_target_s = SUPPORT_JALR_LUI ? S_LUI : S_TRAP;
      default:   decode_target_s = S_TRAP;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = S_TRAP;
    case (state_r)
      S_FETCH:    next_state_s = ready_s ? S_DECODE : S_FETCH;
      S_DECODE:   next_state_s = decode_target_s;
      S_MEMADR:   next_state_s = (i_operand == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state_s = ready_s ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = ready_s ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_EXECUTEI: next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_JALR:     next_state_s = S_JUMP;
      S_JUMP:     next_state_s = S_ALUWB;
      S_LUI:      next_state_s = S_ALUWB;
      S_TRAP:     next_state_s = S_TRAP;
      default:    next_state_s = S_TRAP;
    endcase
  end

  // Output logic: Moore per state, except fetch handshake and branch taken
  always_comb begin
    ctrl_s        = CTRL_IDLE;
    ctrl_s.alu_op = alu_op_s;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_read_en           = 1'b1;
        ctrl_s.alu_a_sel             = A_PC;
        ctrl_s.alu_b_sel             = B_FOUR;
        ctrl_s.result_sel            = RES_ALU_RESULT;
        ctrl_s.pc_write_en           = ready_s;
        ctrl_s.old_pc_write_en       = ready_s;
        ctrl_s.instruction_reg_write = ready_s;
      end
      S_DECODE, S_MEMADR: begin
        ctrl_s.alu_a_sel = (state_r == S_DECODE) ? A_OLD_PC : A_RD1;
        ctrl_s.alu_b_sel = B_IMM;
        ctrl_s.imm_sel   = imm_sel_for(i_operand);
      end
      S_MEMREAD: begin
        ctrl_s.address_src = 1'b1;
        ctrl_s.mem_read_en = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.result_sel   = RES_DATA_Q;
        ctrl_s.reg_write_en = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_s.address_src  = 1'b1;
        ctrl_s.mem_write_en = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_s.alu_a_sel = A_RD1;
        ctrl_s.alu_b_sel = B_RD2;
      end
      S_EXECUTEI, S_JALR: begin
        ctrl_s.alu_a_sel = A_RD1;
        ctrl_s.alu_b_sel = B_IMM;
        ctrl_s.imm_sel   = IMM_I;
      end
      S_ALUWB: begin
        ctrl_s.result_sel   = RES_ALU_OUT_Q;
        ctrl_s.reg_write_en = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_a_sel   = A_RD1;
        ctrl_s.alu_b_sel   = B_RD2;
        ctrl_s.result_sel  = RES_ALU_OUT_Q;
        ctrl_s.imm_sel     = IMM_B;
        ctrl_s.pc_write_en = taken_s;
      end
      S_JUMP: begin
        ctrl_s.alu_a_sel   = A_OLD_PC;
        ctrl_s.alu_b_sel   = B_FOUR;
        ctrl_s.result_sel  = RES_ALU_OUT_Q;
        ctrl_s.pc_write_en = 1'b1;
      end
      S_LUI: begin
        ctrl_s.alu_a_sel = A_ZERO;
        ctrl_s.alu_b_sel = B_IMM;
        ctrl_s.imm_sel   = IMM_U;
      end
      S_TRAP:  ctrl_s.illegal = 1'b1;
      default: ctrl_s.illegal = 1'b1;
    endcase
  end

  assign ctrl_out_s = i_srst ? CTRL_IDLE : ctrl_s;

  assign o_pcWriteEn           = ctrl_out_s.pc_write_en;
  assign o_oldPcWriteEn        = ctrl_out_s.old_pc_write_en;
  assign o_instructionRegWrite = ctrl_out_s.instruction_reg_write;
  assign o_addressSrc          = ctrl_out_s.address_src;
  assign o_memReadEn           = ctrl_out_s.mem_read_en;
  assign o_memWriteEn          = ctrl_out_s.mem_write_en;
  assign o_regWriteEn          = ctrl_out_s.reg_write_en;
  assign o_aluInputASel        = ctrl_out_s.alu_a_sel;
  assign o_aluInputBSel        = ctrl_out_s.alu_b_sel;
  assign o_aluLogicOperation   = ctrl_out_s.alu_op;
  assign o_resultSel           = ctrl_out_s.result_sel;
  assign o_immSel              = ctrl_out_s.imm_sel;
  assign o_illegal             = ctrl_out_s.illegal;
  assign o_state               = state_r;

endmodule

// File: tb/tb_multi_cycle_fsm_controller.sv
// Scoreboard bench: each instruction is expanded into an expected per-cycle
// trace from the instruction-level rules; a monitor compares every cycle.
module tb_multi_cycle_fsm_controller;
  import multi_cycle_fsm_controller_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic [6:0] operand = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7bit5 = 1'b0, zero_flag = 1'b0, lt_flag = 1'b0, mem_ready = 1'b0;
  logic pc_we, old_pc_we, ir_we, addr_src, mem_re, mem_we, reg_we, illegal;
  logic [1:0] a_sel, b_sel, res_sel;
  logic [3:0] alu_op, state;
  logic [2:0] imm_sel;

  always #5 clk = ~clk;

  multi_cycle_fsm_controller dut (
    .i_clk(clk), .i_srst(srst), .i_operand(operand), .i_funct3(funct3),
    .i_funct7bit5(funct7bit5), .i_zeroFlag(zero_flag), .i_ltFlag(lt_flag),
    .i_memReady(mem_ready), .o_pcWriteEn(pc_we), .o_oldPcWriteEn(old_pc_we),
    .o_instructionRegWrite(ir_we), .o_addressSrc(addr_src), .o_memReadEn(mem_re),
    .o_memWriteEn(mem_we), .o_regWriteEn(reg_we), .o_aluInputASel(a_sel),
    .o_aluInputBSel(b_sel), .o_aluLogicOperation(alu_op), .o_resultSel(res_sel),
    .o_immSel(imm_sel), .o_illegal(illegal), .o_state(state)
  );

  // One expected cycle; -1 in an expectation field means "not checked"
  typedef struct {
    logic srst, ready, zero, lt, f7;
    logic [6:0] opc;
    logic [2:0] f3;
    int st, pc, opw, ir, as, mr, mw, rw, a, b, op, res, imm, ill;
  } cyc_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_BAD = 8;

  cyc_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] cur_opc;
  logic [2:0] cur_f3;
  logic cur_f7;

  function automatic cyc_t base(input int st);
    cyc_t c;
    c.srst = 1'b0; c.ready = 1'($urandom_range(0, 1));
    c.zero = 1'($urandom_range(0, 1)); c.lt = 1'($urandom_range(0, 1));
    c.opc = cur_opc; c.f3 = cur_f3; c.f7 = cur_f7; c.st = st;
    c.pc = 0; c.opw = 0; c.ir = 0; c.mr = 0; c.mw = 0; c.rw = 0; c.ill = 0;
    c.as = -1; c.a = -1; c.b = -1; c.op = -1; c.res = -1; c.imm = -1;
    return c;
  endfunction

  function automatic int alu_map(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 1 : 0;
      3'b111:  return 2;
      3'b110:  return 3;
      3'b010:  return 4;
      3'b100:  return 5;
      default: return -1;
    endcase
  endfunction

  task automatic step(input cyc_t c);
    @(posedge clk);
    #1;
    srst = c.srst; mem_ready = c.ready; zero_flag = c.zero; lt_flag = c.lt;
    operand = c.opc; funct3 = c.f3; funct7bit5 = c.f7;
    exp_q.push_back(c);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    if (exp >= 0) begin
      n_chk++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected cycle
  always @(negedge clk) begin
    cyc_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", int'(state), e.st);
      chk("pcWriteEn", int'(pc_we), e.pc);
      chk("oldPcWriteEn", int'(old_pc_we), e.opw);
      chk("instructionRegWrite", int'(ir_we), e.ir);
      chk("addressSrc", int'(addr_src), e.as);
      chk("memReadEn", int'(mem_re), e.mr);
      chk("memWriteEn", int'(mem_we), e.mw);
      chk("regWriteEn", int'(reg_we), e.rw);
      chk("aluInputASel", int'(a_sel), e.a);
      chk("aluInputBSel", int'(b_sel), e.b);
      chk("aluLogicOperation", int'(alu_op), e.op);
      chk("resultSel", int'(res_sel), e.res);
      chk("immSel", int'(imm_sel), e.imm);
      chk("illegal", int'(illegal), e.ill);
    end
  end

  task automatic reset_cycle(input logic ready);
    cyc_t c;
    c = base(-1);
    c.srst = 1'b1; c.ready = ready; c.ill = -1;
    c.as = 0; c.a = 0; c.b = 0; c.op = 0; c.res = 0; c.imm = 0;
    step(c);
  endtask

  task automatic simple(input int st, input int a, input int b, input int op,
                        input int res, input int imm, input int rw);
    cyc_t c;
    c = base(st);
    c.a = a; c.b = b; c.op = op; c.res = res; c.imm = imm; c.rw = rw;
    step(c);
  endtask

  task automatic do_instr(input int kind, input logic [2:0] f3, input logic f7,
                          input int wf, input int wm, input logic zf, input logic lf,
                          input int hold, input bit rst_mem, input logic [6:0] bad_opc);
    cyc_t c;
    bit legal;
    int imm;
    case (kind)
      K_LW:    begin cur_opc = 7'h03; imm = 0;  legal = (f3 == 3'b010); end
      K_SW:    begin cur_opc = 7'h23; imm = 1;  legal = (f3 == 3'b010); end
      K_R:     begin cur_opc = 7'h33; imm = -1; legal = (alu_map(f3, f7, 1'b1) >= 0); end
      K_I:     begin cur_opc = 7'h13; imm = 0;  legal = (alu_map(f3, f7, 1'b0) >= 0); end
      K_BR:    begin cur_opc = 7'h63; imm = 2;  legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5); end
      K_JAL:   begin cur_opc = 7'h6F; imm = 3;  legal = 1'b1; end
      K_JALR:  begin cur_opc = 7'h67; imm = 0;  legal = (f3 == 3'd0); end
      K_LUI:   begin cur_opc = 7'h37; imm = 4;  legal = 1'b1; end
      default: begin cur_opc = bad_opc; imm = -1; legal = 1'b0; end
    endcase
    cur_f3 = f3; cur_f7 = f7;
    for (int i = 0; i <= wf; i++) begin
      c = base(int'(S_FETCH));
      c.ready = (i == wf); c.as = 0; c.mr = 1; c.a = 0; c.b = 2; c.op = 0; c.res = 2;
      c.pc = int'(c.ready); c.opw = int'(c.ready); c.ir = int'(c.ready);
      step(c);
    end
    simple(int'(S_DECODE), 1, 1, 0, -1, imm, 0);
    if (!legal) begin
      for (int i = 0; i < hold; i++) begin
        c = base(int'(S_TRAP));
        c.ill = 1;
        step(c);
      end
      reset_cycle(1'($urandom_range(0, 1)));
    end else begin
      case (kind)
        K_LW, K_SW: begin
          simple(int'(S_MEMADR), 2, 1, 0, -1, imm, 0);
          for (int i = 0; i <= wm; i++) begin
            c = base((kind == K_LW) ? int'(S_MEMREAD) : int'(S_MEMWRITE));
            c.ready = (i == wm); c.as = 1;
            if (kind == K_LW) c.mr = 1; else c.mw = 1;
            if (rst_mem && kind == K_SW && i == wm) reset_cycle(1'b0);
            else step(c);
          end
          if (kind == K_LW) simple(int'(S_MEMWB), -1, -1, -1, 1, -1, 1);
        end
        K_R, K_I: begin
          if (kind == K_R) simple(int'(S_EXECUTER), 2, 0, alu_map(f3, f7, 1'b1), -1, -1, 0);
          else simple(int'(S_EXECUTEI), 2, 1, alu_map(f3, f7, 1'b0), -1, -1, 0);
          simple(int'(S_ALUWB), -1, -1, -1, 0, -1, 1);
        end
        K_BR: begin
          c = base(int'(S_BRANCH));
          c.zero = zf; c.lt = lf; c.a = 2; c.b = 0; c.op = 1; c.res = 0;
          case (f3)
            3'd0:    c.pc = int'(zf);
            3'd1:    c.pc = int'(!zf);
            3'd4:    c.pc = int'(lf);
            default: c.pc = int'(!lf);
          endcase
          step(c);
        end
        default: begin
          if (kind == K_JALR) simple(int'(S_JALR), 2, 1, 0, -1, 0, 0);
          if (kind == K_LUI) simple(int'(S_LUI), 3, 1, 0, -1, 4, 0);
          else begin
            c = base(int'(S_JUMP));
            c.a = 1; c.b = 2; c.op = 0; c.res = 0; c.pc = 1;
            step(c);
          end
          simple(int'(S_ALUWB), -1, -1, -1, 0, -1, 1);
        end
      endcase
    end
  endtask

  initial begin
    logic [6:0] bad_tab [5];
    logic [2:0] alu_tab [5];
    logic [2:0] br_tab [4];
    int kind, wf, wm;
    logic [2:0] f3;
    bad_tab = '{7'h7F, 7'h0F, 7'h73, 7'h17, 7'h00};
    alu_tab = '{3'd0, 3'd7, 3'd6, 3'd2, 3'd4};
    br_tab  = '{3'd0, 3'd1, 3'd4, 3'd5};
    cur_opc = 7'h13; cur_f3 = 3'd0; cur_f7 = 1'b0;
    reset_cycle(1'b1);
    reset_cycle(1'b1);
    // Directed scenarios
    do_instr(K_I,   3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);  // addi x1,x0,5
    do_instr(K_LW,  3'd2, 1'b0, 0, 2, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_BR,  3'd1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_BR,  3'd1, 1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_BR,  3'd4, 1'b0, 1, 0, 1'b0, 1'b1, 0, 1'b0, 7'h00);
    do_instr(K_BR,  3'd5, 1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 7'h00);
    do_instr(K_JAL, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_BAD, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 10, 1'b0, 7'h7F);
    do_instr(K_SW,  3'd2, 1'b0, 0, 2, 1'b0, 1'b0, 0, 1'b1, 7'h00);
    do_instr(K_SW,  3'd2, 1'b0, 2, 1, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_R,   3'd0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_I,   3'd0, 1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_JALR, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_LUI, 3'd3, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 7'h00);
    do_instr(K_R,   3'd1, 1'b0, 0, 0, 1'b0, 1'b0, 2, 1'b0, 7'h00);
    do_instr(K_LW,  3'd0, 1'b0, 0, 0, 1'b0, 1'b0, 2, 1'b0, 7'h00);
    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        K_LW, K_SW: f3 = 3'd2;
        K_R, K_I:   f3 = alu_tab[$urandom_range(0, 4)];
        K_BR:       f3 = br_tab[$urandom_range(0, 3)];
        K_JALR:     f3 = 3'd0;
        default:    f3 = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      do_instr(kind, f3, 1'($urandom_range(0, 1)), wf, wm, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(1, 3),
               ($urandom_range(0, 5) == 0), bad_tab[$urandom_range(0, 4)]);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_fsm_controller.md
Name: multi_cycle_fsm_controller

Overview:
- Main control FSM for the multi-cycle RV32I core. It replaces the combinational single-cycle controller.
- Sequences fetch, decode, execute, memory and writeback over several cycles, driving all enables and mux selects of the multi-cycle datapath.
- Generalises the original instruction subset with bne/blt/bge, jalr and lui, a variable-latency memory ready handshake, and a sticky illegal-instruction trap.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for i_memReady; 0 = memory treated as always ready.
SUPPORT_BRANCH_EXT, 1, 1 = bne/blt/bge legal; 0 = only beq legal.
SUPPORT_JALR_LUI, 1, 1 = jalr/lui legal; 0 = their opcodes trap.

Ports:
i_clk  in  1  clock
i_srst  in  1  synchronous active-high reset
i_operand  in  7  instruction_q[6:0]
i_funct3  in  3  instruction_q[14:12]
i_funct7bit5  in  1  instruction_q[30]
i_zeroFlag  in  1  ALU result == 0
i_ltFlag  in  1  ALU signed a < b
i_memReady  in  1  memory access completes this cycle
o_pcWriteEn  out  1  PC register load
o_oldPcWriteEn  out  1  oldPc load
o_instructionRegWrite  out  1  instruction_q load
o_addressSrc  out  1  0 = pc, 1 = aluOutput_q
o_memReadEn  out  1  memory read request
o_memWriteEn  out  1  memory write request
o_regWriteEn  out  1  register file write
o_aluInputASel  out  2  PC=0, OLD_PC=1, REG_READ_DATA_1=2, ZERO=3
o_aluInputBSel  out  2  REG_READ_DATA_2=0, IMMEDIATE_EXTENDED=1, FOUR=2
o_aluLogicOperation  out  4  ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5
o_resultSel  out  2  ALU_OUT_Q=0, DATA_Q=1, ALU_RESULT=2 (drives nextPc and regWriteData)
o_immSel  out  3  I=0, S=1, B=2, J=3, U=4
o_illegal  out  1  sticky trap flag
o_state  out  4  current state (debug)

Behaviour:
- Reset: state = FETCH, o_illegal = 0. While i_srst is high, all write/enable/request outputs are 0; selects are don't-care but driven to 0.
- Outputs are Moore (functions of state), except where noted. "ready" = i_memReady when MEM_HANDSHAKE = 1, else 1.
- FETCH:
  - Outputs: addressSrc 0, memReadEn 1, A = PC, B = FOUR, ADD, resultSel ALU_RESULT.
  - When ready, assert pcWriteEn, oldPcWriteEn and instructionRegWrite in the same cycle, then go to DECODE.
  - Otherwise hold all three low and stay in FETCH.
- DECODE:
  - Outputs: A = OLD_PC, B = IMM, ADD (target into aluOutput_q); immSel from the opcode.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JUMP; 1100111 -> JALR; 0110111 -> LUI.
  - Any other opcode, a disabled feature, or an unsupported funct3 -> TRAP.
- MEMADR: A = RD1, B = IMM, ADD, immSel I or S. Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: addressSrc 1, memReadEn 1. Wait for ready, then MEMWB.
- MEMWB: resultSel DATA_Q, regWriteEn 1, then FETCH.
- MEMWRITE: addressSrc 1, memWriteEn 1, held until ready, then FETCH. Write occurs exactly once per instruction.
- EXECUTER: A = RD1, B = RD2, op from funct3/funct7bit5, then ALUWB.
  - 000 -> ADD, or SUB when funct7bit5 = 1; 111 -> AND; 110 -> OR; 010 -> SLT; 100 -> XOR.
- EXECUTEI: A = RD1, B = IMM, same funct3 map with funct7bit5 ignored (addi always ADD), then ALUWB.
- ALUWB: resultSel ALU_OUT_Q, regWriteEn 1, then FETCH.
- BRANCH: A = RD1, B = RD2, SUB, resultSel ALU_OUT_Q, then FETCH.
  - pcWriteEn = taken (Mealy on flags).
  - taken: beq = zero; bne = !zero; blt = lt; bge = !lt.
- JALR: A = RD1, B = IMM, ADD, immSel I, then JUMP.
- JUMP: A = OLD_PC, B = FOUR, ADD, resultSel ALU_OUT_Q, pcWriteEn 1, then ALUWB (rd <= oldPc + 4).
- LUI: A = ZERO, B = IMM, immSel U, ADD, then ALUWB.
- TRAP: all enables 0, o_illegal = 1. Remains in TRAP until reset.
- Reset asserted in any state, including mid-MEMWRITE with ready low: next cycle is FETCH with no further write.
- Cycle counts with zero wait: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 4. Each wait cycle adds 1.

Decomposition:
- pa_riscv additions: state enum, aluInputASel/aluInputBSel/resultSel/immSel enums, ALU op constants, opcode constants.
- Sub-module alu_op_decoder: purely combinational map of (state class, funct3, funct7bit5) to aluLogicOperation plus a funct3-legal flag.

Test Plan:
- addi x1,x0,5 (0x00500093), ready tied 1: FETCH -> DECODE -> EXECUTEI -> ALUWB -> FETCH; regWriteEn high only in cycle 4; op ADD.
- lw, i_memReady low for 2 cycles in MEMREAD: stays in MEMREAD for 3 cycles, memReadEn held, MEMWB regWriteEn on the 7th cycle.
- bne with zeroFlag = 0 -> pcWriteEn = 1 in BRANCH; repeat with zeroFlag = 1 -> pcWriteEn = 0; both return to FETCH.
- jal: DECODE -> JUMP (pcWriteEn 1, resultSel ALU_OUT_Q) -> ALUWB (regWriteEn 1).
- Opcode 0x7F: DECODE -> TRAP, o_illegal = 1 held for 10 cycles; reset clears it and returns to FETCH.
- Reset during MEMWRITE with ready = 0: memWriteEn = 0 during reset, state = FETCH after release.
